instr_queue_decode: RTL and testbench

Parametrised instruction buffer and field decoder between fetch and decode. It holds up to DEPTH fetched instructions, each with its PC, in a circular FIFO. Fetch side and decode side each use a valid/ready handshake. The head entry is decoded combinationally into RV32I fields plus a format-aware, sign-extended immediate. A flush input discards all entries on a redirect.

---
 rtl/instr_queue_decode.sv | 155 +++++++++++++++
 tb/tb_instr_queue_decode.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue_decode.sv
// Circular instruction/PC queue between fetch and decode, with combinational
// RV32I field and immediate decode of the head entry.
module instr_queue_decode #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_instr,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [6:0]               opcode,
  output logic [4:0]               rd,
  output logic [2:0]               funct3,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [6:0]               funct7,
  output logic [XLEN-1:0]          imm,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  function automatic logic [XLEN-1:0] decode_imm(input logic [XLEN-1:0] instr);
    logic [XLEN-1:0] imm_v;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm_v = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm_v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm_v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_v = {instr[31:12], 12'b0};
      OP_JAL:
        imm_v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm_v = {XLEN{1'b0}};
    endcase
    return imm_v;
  endfunction

  function automatic logic opcode_legal(input logic [6:0] op);
    logic ok_v;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_FENCE: ok_v = 1'b1;
      default:                                    ok_v = 1'b0;
    endcase
    return ok_v;
  endfunction

  logic [XLEN-1:0] instr_mem_r [DEPTH];
  logic [PC_W-1:0] pc_mem_r    [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            push_s;
  logic            pop_s;
  logic [XLEN-1:0] head_instr_s;
  logic [PC_W-1:0] head_pc_s;

  assign in_ready     = (count_r < DEPTH_C);
  assign out_valid    = (count_r != {CW{1'b0}});
  assign count        = count_r;
  // Flush wins over both handshakes, so a concurrent push is simply dropped.
  assign push_s       = in_valid & in_ready & ~flush;
  assign pop_s        = out_valid & out_ready & ~flush;
  assign head_instr_s = instr_mem_r[rd_ptr_r];
  assign head_pc_s    = pc_mem_r[rd_ptr_r];

  // Entry storage: written on accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= in_instr;
      pc_mem_r[wr_ptr_r]    <= in_pc;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head decode, forced to zero while the queue is empty.
  always_comb begin
    out_instr = {XLEN{1'b0}};
    out_pc    = {PC_W{1'b0}};
    opcode    = 7'd0;
    rd        = 5'd0;
    funct3    = 3'd0;
    rs1       = 5'd0;
    rs2       = 5'd0;
    funct7    = 7'd0;
    imm       = {XLEN{1'b0}};
    illegal   = 1'b0;
    if (out_valid) begin
      out_instr = head_instr_s;
      out_pc    = head_pc_s;
      opcode    = head_instr_s[6:0];
      rd        = head_instr_s[11:7];
      funct3    = head_instr_s[14:12];
      rs1       = head_instr_s[19:15];
      rs2       = head_instr_s[24:20];
      funct7    = head_instr_s[31:25];
      imm       = decode_imm(head_instr_s);
      illegal   = (head_instr_s[1:0] != 2'b11) | ~opcode_legal(head_instr_s[6:0]);
    end else begin
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_queue_decode.sv
// Self-checking bench for instr_queue_decode: decode vector table, queue
// corner sequences, and randomized traffic against a queue-based model.
module tb_instr_queue_decode;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        illegal;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_queue_decode #(.DEPTH(DEPTH), .XLEN(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .illegal(illegal), .count(count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[10];
  logic [31:0] mq_instr[$];
  logic [31:0] mq_pc[$];
  logic [6:0]  ops[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Immediate from the ISA bit-scatter rules, built with shifts and masks.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic [31:0] sgn;
    sgn = w[31] ? 32'hFFFF_FFFF : 32'h0000_0000;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: return (sgn << 12) | (w >> 20);
      7'h23: return (sgn << 12) | (((w >> 25) & 32'h7F) << 5) | ((w >> 7) & 32'h1F);
      7'h63: return (sgn << 12) | (((w >> 7) & 32'h1) << 11) |
                    (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
      7'h37, 7'h17: return w & 32'hFFFF_F000;
      7'h6F: return (sgn << 20) | (w & 32'h000F_F000) | (((w >> 20) & 32'h1) << 11) |
                    (((w >> 21) & 32'h3FF) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return !(op inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
                        7'h6F, 7'h33, 7'h0F});
  endfunction

  task automatic check_head(input string tag, input logic [31:0] w, input logic [31:0] pc);
    logic [31:0] t;
    t = w;
    chk({tag, ".valid"},  {31'd0, out_valid}, 32'd1);
    chk({tag, ".instr"},  out_instr, t);
    chk({tag, ".pc"},     out_pc, pc);
    chk({tag, ".opcode"}, {25'd0, opcode}, {25'd0, t[6:0]});
    chk({tag, ".rd"},     {27'd0, rd}, {27'd0, t[11:7]});
    chk({tag, ".rs1"},    {27'd0, rs1}, {27'd0, t[19:15]});
    chk({tag, ".imm"},    imm, ref_imm(t));
    chk({tag, ".ill"},    {31'd0, illegal}, {31'd0, ref_illegal(t)});
  endtask

  task automatic check_empty(input string tag);
    chk({tag, ".count"}, {29'd0, count}, 32'd0);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".instr"}, out_instr, 32'd0);
    chk({tag, ".opcode"}, {25'd0, opcode}, 32'd0);
    chk({tag, ".imm"}, imm, 32'd0);
    chk({tag, ".ill"}, {31'd0, illegal}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = w; in_pc = pc; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h00500093, 7'h13, 5'd1,  3'd0, 5'd0, 5'd5,  7'h00, 32'h00000005, 1'b0};
    vecs[1] = '{32'h0020A423, 7'h23, 5'd8,  3'd2, 5'd1, 5'd2,  7'h00, 32'h00000008, 1'b0};
    vecs[2] = '{32'hFE000FE3, 7'h63, 5'd31, 3'd0, 5'd0, 5'd0,  7'h7F, 32'hFFFFFFFE, 1'b0};
    vecs[3] = '{32'h123452B7, 7'h37, 5'd5,  3'd5, 5'd8, 5'd3,  7'h09, 32'h12345000, 1'b0};
    vecs[4] = '{32'h00000000, 7'h00, 5'd0,  3'd0, 5'd0, 5'd0,  7'h00, 32'h00000000, 1'b1};
    vecs[5] = '{32'h00000033, 7'h33, 5'd0,  3'd0, 5'd0, 5'd0,  7'h00, 32'h00000000, 1'b0};
    vecs[6] = '{32'h0080006F, 7'h6F, 5'd0,  3'd0, 5'd0, 5'd8,  7'h00, 32'h00000008, 1'b0};
    vecs[7] = '{32'hFFF00093, 7'h13, 5'd1,  3'd0, 5'd0, 5'd31, 7'h7F, 32'hFFFFFFFF, 1'b0};
    vecs[8] = '{32'h00000001, 7'h01, 5'd0,  3'd0, 5'd0, 5'd0,  7'h00, 32'h00000000, 1'b1};
    vecs[9] = '{32'h80000097, 7'h17, 5'd1,  3'd0, 5'd0, 5'd0,  7'h40, 32'h80000000, 1'b0};
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};

    reset = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check_empty("reset");
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;

    // Decode table: push one entry, inspect it, pop it.
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].instr, 32'h100 + 32'(i) * 32'd4);
      chk($sformatf("vec%0d.count", i), {29'd0, count}, 32'd1);
      chk($sformatf("vec%0d.valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d.pc", i), out_pc, 32'h100 + 32'(i) * 32'd4);
      chk($sformatf("vec%0d.opcode", i), {25'd0, opcode}, {25'd0, vecs[i].op});
      chk($sformatf("vec%0d.rd", i), {27'd0, rd}, {27'd0, vecs[i].rd});
      chk($sformatf("vec%0d.funct3", i), {29'd0, funct3}, {29'd0, vecs[i].f3});
      chk($sformatf("vec%0d.rs1", i), {27'd0, rs1}, {27'd0, vecs[i].rs1});
      chk($sformatf("vec%0d.rs2", i), {27'd0, rs2}, {27'd0, vecs[i].rs2});
      chk($sformatf("vec%0d.funct7", i), {25'd0, funct7}, {25'd0, vecs[i].f7});
      chk($sformatf("vec%0d.imm", i), imm, vecs[i].imm);
      chk($sformatf("vec%0d.illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("vec%0d.popped", i), {29'd0, count}, 32'd0);
    end

    // Full: no push accepted; pop with a rejected push drops to DEPTH-1.
    for (int k = 0; k < DEPTH; k++) push(32'h00000013 | (32'(k) << 20), 32'h200 + 32'(k) * 32'd4);
    chk("full.count", {29'd0, count}, 32'd4);
    chk("full.in_ready", {31'd0, in_ready}, 32'd0);
    push(32'h00000093, 32'h300);
    chk("full.no_push", {29'd0, count}, 32'd4);
    chk("full.head", out_pc, 32'h200);
    in_valid = 1'b1; in_instr = 32'h00000093; in_pc = 32'h300; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("full.pop_count", {29'd0, count}, 32'd3);
    chk("full.in_ready_rise", {31'd0, in_ready}, 32'd1);
    for (int k = 1; k < DEPTH; k++) begin
      check_head($sformatf("drain%0d", k), 32'h00000013 | (32'(k) << 20), 32'h200 + 32'(k) * 32'd4);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("drain.count", {29'd0, count}, 32'd0);

    // Flush beats concurrent push and pop.
    push(32'h00000000, 32'h400);
    push(32'h00000000, 32'h404);
    chk("flush.pre", {29'd0, count}, 32'd2);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h408; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_empty("flush");
    tick();
    chk("flush.dropped", {29'd0, count}, 32'd0);

    // Back-to-back push+pop wraps the pointers.
    push(32'h00000013, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("wrap%0d.pc", k), out_pc, 32'(k - 1) * 32'd4);
      chk($sformatf("wrap%0d.count", k), {29'd0, count}, 32'd1);
      in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'(k) * 32'd4; out_ready = 1'b1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap.last_pc", out_pc, 32'h28);
    chk("wrap.count", {29'd0, count}, 32'd1);

    // Asynchronous reset mid-stream.
    push(32'h00000033, 32'h500);
    chk("midrst.pre", {29'd0, count}, 32'd2);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst.count", {29'd0, count}, 32'd0);
    chk("midrst.valid", {31'd0, out_valid}, 32'd0);
    chk("midrst.ill", {31'd0, illegal}, 32'd0);
    tick();
    reset = 1'b1;

    // Randomized traffic against a queue model.
    mq_instr.delete(); mq_pc.delete();
    for (int c = 0; c < 400; c++) begin
      logic [31:0] w;
      logic        do_push;
      logic        do_pop;
      chk($sformatf("rnd%0d.count", c), {29'd0, count}, 32'(mq_instr.size()));
      chk($sformatf("rnd%0d.in_ready", c), {31'd0, in_ready}, {31'd0, mq_instr.size() < DEPTH});
      if (mq_instr.size() > 0) begin
        check_head($sformatf("rnd%0d", c), mq_instr[0], mq_pc[0]);
        chk($sformatf("rnd%0d.rs2", c), {27'd0, rs2}, {27'd0, mq_instr[0][24:20]});
        chk($sformatf("rnd%0d.f3", c), {29'd0, funct3}, {29'd0, mq_instr[0][14:12]});
        chk($sformatf("rnd%0d.f7", c), {25'd0, funct7}, {25'd0, mq_instr[0][31:25]});
      end else begin
        check_empty($sformatf("rnd%0d", c));
      end
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_instr  = w;
      in_pc     = $urandom & 32'hFFFF_FFFC;
      do_push = in_valid && (mq_instr.size() < DEPTH) && !flush;
      do_pop  = out_ready && (mq_instr.size() > 0) && !flush;
      tick();
      if (flush) begin
        mq_instr.delete(); mq_pc.delete();
      end else begin
        if (do_pop) begin
          void'(mq_instr.pop_front()); void'(mq_pc.pop_front());
        end
        if (do_push) begin
          mq_instr.push_back(w); mq_pc.push_back(in_pc);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
